// File: rtl/uart_mmio_port.sv
// Memory-mapped UART peripheral: mid-bit sampling RX feeding a byte FIFO,
// single-byte TX serializer, sticky status flags and a registered RX interrupt.
// Bit time is DIV = CLK_HZ/BAUD clock cycles (DIV must be at least 2).
module uart_mmio_port #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clkout,
    input  logic        ext_reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  byte_select,
    output logic [31:0] data_out,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_irq
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CW-1:0]    FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;

    // ---------------- bus decode ----------------
    logic ren_q_r;
    logic wr_en_s, tx_wr_s, pop_s, push_s, push_ok_s, frame_err_set_s;
    logic rx_overflow_r, frame_err_r, ctrl_irq_en_r, rx_irq_r;
    logic [CW-1:0] rx_count_r;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic          rx_nonempty_s, rx_full_s;

    assign wr_en_s       = wen & byte_select[0];
    assign tx_wr_s       = wr_en_s & (address == 2'd1);
    assign rx_nonempty_s = (rx_count_r != {CW{1'b0}});
    assign rx_full_s     = (rx_count_r == FULL_C);
    assign pop_s         = ren & ~ren_q_r & (address == 2'd0) & rx_nonempty_s;

    logic unused_s;
    assign unused_s = ^{data_in[31:8], byte_select[3:1]};

    // Read-strobe history so a held ren pops only once
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            ren_q_r <= 1'b0;
        end else begin
            ren_q_r <= ren;
        end
    end

    // ---------------- RX path ----------------
    logic rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t rx_state_r, rx_state_n;
    logic [CNT_W-1:0] rx_cnt_r, rx_cnt_n;
    logic [7:0] rx_shift_r, rx_shift_n;
    logic [2:0] rx_bit_r, rx_bit_n;
    logic rx_expire_s;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_expire_s = (rx_cnt_r == ONE_C);

    // RX state and datapath registers
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= {CNT_W{1'b0}};
            rx_shift_r <= 8'h00;
            rx_bit_r   <= 3'd0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_shift_r <= rx_shift_n;
            rx_bit_r   <= rx_bit_n;
        end
    end

    // RX next state: half-bit wait to mid start bit, then one sample per bit time
    always_comb begin
        rx_state_n      = rx_state_r;
        rx_cnt_n        = rx_cnt_r;
        rx_shift_n      = rx_shift_r;
        rx_bit_n        = rx_bit_r;
        push_s          = 1'b0;
        frame_err_set_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF_C;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_expire_s) begin
                    if (!rx_sync_r) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = DIV_C;
                        rx_bit_n   = 3'd0;
                    end else begin
                        rx_state_n = RX_IDLE;   // false start
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - ONE_C;
                end
            end
            RX_DATA: begin
                if (rx_expire_s) begin
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_n   = DIV_C;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - ONE_C;
                end
            end
            RX_STOP: begin
                if (rx_expire_s) begin
                    rx_state_n = RX_IDLE;
                    if (rx_sync_r) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_set_s = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - ONE_C;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    // A pop in the same cycle frees the slot, so a push at full is still accepted
    assign push_ok_s = push_s & (~rx_full_s | pop_s);

    // FIFO pointers and occupancy
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            rx_count_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_s})
                2'b10:   rx_count_r <= rx_count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   rx_count_r <= rx_count_r - {{(CW-1){1'b0}}, 1'b1};
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // FIFO storage (no reset needed; head is masked while empty)
    always_ff @(posedge clkout) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_shift_r;
        end
    end

    // ---------------- TX path ----------------
    tx_state_t tx_state_r, tx_state_n;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_n;
    logic [7:0] tx_shift_r, tx_shift_n;
    logic [2:0] tx_bit_r, tx_bit_n;
    logic uart_tx_r, uart_tx_n;
    logic tx_expire_s, tx_busy_s;

    assign tx_expire_s = (tx_cnt_r == ONE_C);
    assign tx_busy_s   = (tx_state_r != TX_IDLE);

    // TX state, datapath and line register
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= {CNT_W{1'b0}};
            tx_shift_r <= 8'h00;
            tx_bit_r   <= 3'd0;
            uart_tx_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_shift_r <= tx_shift_n;
            tx_bit_r   <= tx_bit_n;
            uart_tx_r  <= uart_tx_n;
        end
    end

    // TX next state: each line level is registered and held for DIV cycles
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_shift_n = tx_shift_r;
        tx_bit_n   = tx_bit_r;
        uart_tx_n  = uart_tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_wr_s) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = DIV_C;
                    tx_shift_n = data_in[7:0];
                    uart_tx_n  = 1'b0;
                end else begin
                    uart_tx_n = 1'b1;
                end
            end
            TX_START: begin
                if (tx_expire_s) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = DIV_C;
                    tx_bit_n   = 3'd0;
                    uart_tx_n  = tx_shift_r[0];
                end else begin
                    tx_cnt_n = tx_cnt_r - ONE_C;
                end
            end
            TX_DATA: begin
                if (tx_expire_s) begin
                    tx_cnt_n = DIV_C;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                        uart_tx_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                        uart_tx_n  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - ONE_C;
                end
            end
            TX_STOP: begin
                if (tx_expire_s) begin
                    tx_state_n = TX_IDLE;
                    uart_tx_n  = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt_r - ONE_C;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                uart_tx_n  = 1'b1;
            end
        endcase
    end

    assign uart_tx = uart_tx_r;

    // ---------------- status, control, interrupt ----------------
    // Sticky flags: a set event in the same cycle as a clear wins
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            rx_overflow_r <= 1'b0;
            frame_err_r   <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
        end else begin
            if (push_s && rx_full_s && !pop_s) begin
                rx_overflow_r <= 1'b1;
            end else if (wr_en_s && (address == 2'd2) && data_in[1]) begin
                rx_overflow_r <= 1'b0;
            end
            if (frame_err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (wr_en_s && (address == 2'd2) && data_in[3]) begin
                frame_err_r <= 1'b0;
            end
            if (wr_en_s && (address == 2'd3)) begin
                ctrl_irq_en_r <= data_in[0];
            end
        end
    end

    // Interrupt follows enable and FIFO occupancy one cycle later
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            rx_irq_r <= 1'b0;
        end else begin
            rx_irq_r <= ctrl_irq_en_r & rx_nonempty_s;
        end
    end

    assign rx_irq = rx_irq_r;

    logic [7:0] head_s;
    logic [4:0] count5_s;
    assign head_s   = rx_nonempty_s ? fifo_mem_r[rd_ptr_r] : 8'h00;
    assign count5_s = 5'(rx_count_r);

    // Read mux, combinational from address and current state
    always_comb begin
        data_out = 32'h0000_0000;
        case (address)
            2'd0:    data_out = {23'd0, rx_nonempty_s, head_s};
            2'd1:    data_out = 32'h0000_0000;
            2'd2:    data_out = {23'd0, count5_s, frame_err_r, tx_busy_s, rx_overflow_r, rx_nonempty_s};
            2'd3:    data_out = {31'd0, ctrl_irq_en_r};
            default: data_out = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Directed-plus-random bench for uart_mmio_port with a queue-based reference model.
module tb_uart_mmio_port;

    localparam int DIV   = 27000000 / 115200;
    localparam int DEPTH = 16;

    logic        clkout;
    logic        ext_reset;
    logic        ren;
    logic        wen;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [3:0]  byte_select;
    logic [31:0] data_out;
    logic        uart_rx;
    logic        uart_tx;
    logic        rx_irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] q[$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;

    uart_mmio_port dut (
        .clkout      (clkout),
        .ext_reset   (ext_reset),
        .ren         (ren),
        .wen         (wen),
        .address     (address),
        .data_in     (data_in),
        .byte_select (byte_select),
        .data_out    (data_out),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .rx_irq      (rx_irq)
    );

    initial clkout = 1'b0;
    always #5 clkout = ~clkout;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkout);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        exp_status = {23'd0, 5'(q.size()), m_ferr, busy, m_ovf, (q.size() != 0)};
    endfunction

    function automatic logic [31:0] exp_rxdata();
        if (q.size() != 0) exp_rxdata = {23'd0, 1'b1, q[0]};
        else               exp_rxdata = 32'h0;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; data_in = d; byte_select = be; wen = 1'b1;
        cyc(1);
        wen = 1'b0; byte_select = 4'h0;
    endtask

    task automatic read_status(input string tag);
        address = 2'd2;
        #1;
        check(tag, data_out, exp_status(1'b0));
    endtask

    // single RXDATA read strobe; pops the model when a byte is present
    task automatic pop_check(input string tag);
        address = 2'd0; ren = 1'b1;
        #1;
        check(tag, data_out, exp_rxdata());
        cyc(1);
        ren = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        cyc(1);
    endtask

    // drive one serial frame at DIV cycles per bit and update the model
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(DIV);
        end
        uart_rx = stop;
        cyc(DIV);
        uart_rx = 1'b1;
        if (!stop)                 m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                       m_ovf = 1'b1;
    endtask

    // write a byte to TXDATA and check line and busy at both ends of every bit
    task automatic tx_check(input logic [7:0] b, input bit second_write);
        logic [9:0] frame;
        logic       exp_tx;
        frame = {1'b1, b, 1'b0};
        bus_write(2'd1, {24'd0, b}, 4'h1);
        address = 2'd2;
        #1;
        for (int j = 0; j <= 10 * DIV; j++) begin
            exp_tx = (j == 10 * DIV) ? 1'b1 : frame[j / DIV];
            if ((j % DIV == 0) || (j % DIV == DIV - 1) || (j == 10 * DIV)) begin
                check($sformatf("tx_line_c%0d", j), {31'd0, uart_tx}, {31'd0, exp_tx});
                check($sformatf("tx_busy_c%0d", j), {31'd0, data_out[2]}, {31'd0, (j < 10 * DIV)});
            end
            if (second_write && j == 1000) begin
                address = 2'd1; data_in = 32'h0000_00FF; byte_select = 4'h1; wen = 1'b1;
            end else if (second_write && j == 1001) begin
                address = 2'd2; wen = 1'b0; byte_select = 4'h0;
            end
            if (j < 10 * DIV) cyc(1);
        end
    endtask

    logic [7:0] rb;

    initial begin
        ext_reset = 1'b0; ren = 1'b0; wen = 1'b0; address = 2'd0;
        data_in = 32'h0; byte_select = 4'h0; uart_rx = 1'b1;

        // reset
        cyc(5);
        check("rst_tx", {31'd0, uart_tx}, 32'h1);
        check("rst_irq", {31'd0, rx_irq}, 32'h0);
        address = 2'd2; #1;
        check("rst_status", data_out, 32'h0);
        address = 2'd3; #1;
        check("rst_ctrl", data_out, 32'h0);
        ext_reset = 1'b1;
        cyc(3);
        read_status("post_rst_status");
        address = 2'd1; #1;
        check("txdata_reads0", data_out, 32'h0);

        // TX: fixed pattern with an ignored mid-frame write, then a back-to-back random byte
        tx_check(8'h55, 1'b1);
        tx_check(8'($urandom), 1'b0);
        cyc(2);

        // RX single byte and held-ren single pop
        send_byte(8'hA3, 1'b1);
        cyc(4);
        read_status("rx1_status");
        address = 2'd0; #1;
        check("rx1_rxdata", data_out, 32'h0000_01A3);
        ren = 1'b1;
        cyc(6);
        ren = 1'b0;
        void'(q.pop_front());
        cyc(1);
        check("rx1_after_hold", data_out, 32'h0);
        read_status("rx1_status_empty");

        // random bytes through the FIFO
        for (int k = 0; k < 3; k++) begin
            send_byte(8'($urandom), 1'b1);
            cyc(4);
        end
        read_status("rand_status");
        for (int k = 0; k < 3; k++) pop_check($sformatf("rand_pop%0d", k));
        pop_check("pop_empty");

        // false start glitch, then a bad stop bit
        uart_rx = 1'b0; cyc(50); uart_rx = 1'b1; cyc(300);
        read_status("glitch_status");
        send_byte(8'($urandom), 1'b0);
        cyc(4);
        read_status("ferr_status");
        bus_write(2'd2, 32'h8, 4'h1);
        m_ferr = 1'b0;
        read_status("ferr_clear");

        // interrupt: masked write ignored, then enabled
        bus_write(2'd3, 32'h1, 4'hE);
        address = 2'd3; #1;
        check("ctrl_masked_write", data_out, 32'h0);
        bus_write(2'd3, 32'h1, 4'h1);
        address = 2'd3; #1;
        check("ctrl_set", data_out, 32'h1);
        cyc(2);
        check("irq_empty", {31'd0, rx_irq}, 32'h0);
        send_byte(8'($urandom), 1'b1);
        cyc(4);
        check("irq_set", {31'd0, rx_irq}, 32'h1);
        pop_check("irq_pop");
        cyc(1);
        check("irq_clear", {31'd0, rx_irq}, 32'h0);
        bus_write(2'd3, 32'h0, 4'h1);

        // overflow with 17 bytes
        for (int k = 0; k <= DEPTH; k++) begin
            send_byte(8'(k), 1'b1);
            cyc(4);
        end
        read_status("ovf_status");
        bus_write(2'd2, 32'h2, 4'h1);
        m_ovf = 1'b0;
        read_status("ovf_clear");

        // pop on the same cycle the RX frame pushes into a full FIFO
        cyc(1);
        fork
            send_byte(8'hC5, 1'b1);
            begin
                cyc(3 + DIV / 2 + 9 * DIV - 1);
                address = 2'd0; ren = 1'b1;
                #1;
                check("collide_pop", data_out, exp_rxdata());
                void'(q.pop_front());
                cyc(1);
                ren = 1'b0;
            end
        join
        cyc(4);
        read_status("collide_status");
        while (q.size() != 0) pop_check($sformatf("drain_%0d", q.size()));
        read_status("final_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_port.md
Name: uart_mmio_port

Overview:
Memory-mapped UART peripheral on the SoC data bus. The bus decodes the UART address window and drives ren/wen/address into this block; the block returns data_out to the bus read mux. It contains an oversampling-free mid-bit RX deserializer feeding an RX FIFO, a single-byte TX serializer, and sticky status flags. It also raises a level interrupt for the CPU interrupt path.

Parameters:
CLK_HZ, 27000000, clkout frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/BAUD, integer-truncated (234 at defaults)
FIFO_DEPTH, 16, RX FIFO entries; power of two, minimum 2

Ports:
clkout  in  1  system clock
ext_reset  in  1  asynchronous active-low reset
ren  in  1  bus read strobe for this window
wen  in  1  bus write strobe for this window
address  in  2  word index (data_addr[3:2])
data_in  in  32  write data
byte_select  in  4  byte lanes; a write takes effect only if byte_select[0]=1
data_out  out  32  read data, combinational from address and state
uart_rx  in  1  serial input, idle high
uart_tx  out  1  serial output, idle high
rx_irq  out  1  level interrupt = ctrl_irq_en & rx_nonempty

Behaviour:
- Reset is ext_reset, asynchronous, active-low, on clock clkout.
- Reset values: uart_tx=1, FIFO empty (count 0), all sticky flags 0, ctrl_irq_en=0, rx_irq=0, TX and RX FSMs IDLE, RX synchroniser flops = 1.
- Reset asserted mid-frame aborts both FSMs immediately. The partial RX byte is discarded. uart_tx returns to 1 asynchronously.
- Register map, reads:
  - 0 RXDATA: [8]=valid (FIFO non-empty), [7:0]=FIFO head (0 when empty), other bits 0.
  - 1 TXDATA: reads 0.
  - 2 STATUS: [0]=rx_nonempty, [1]=rx_overflow, [2]=tx_busy, [3]=frame_err, [8:4]=rx count (0..FIFO_DEPTH), other bits 0.
  - 3 CTRL: [0]=ctrl_irq_en.
- Pop: on the rising edge of ren (ren & ~ren_q) with address=0 and FIFO non-empty. Exactly one pop per strobe, even if ren is held for multiple cycles. Popping an empty FIFO has no effect.
- Writes (wen & byte_select[0]):
  - addr1 loads data_in[7:0] into TX if TX is IDLE. If TX is busy, the write is ignored.
  - addr2: data_in[1]=1 clears rx_overflow; data_in[3]=1 clears frame_err.
  - addr3: sets ctrl_irq_en = data_in[0].
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronised 1->0 transition enters START with counter = DIV/2.
  - START: when the counter expires, sample the line. 0 enters DATA with counter = DIV; 1 is a false start and returns to IDLE.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV. 1 pushes the byte into the FIFO. 0 drops the byte, sets frame_err, and returns to IDLE.
- FIFO:
  - Push when full: byte dropped, rx_overflow set, contents unchanged.
  - Simultaneous push and pop in one cycle: both occur, count unchanged. Valid also when full (the pop frees the slot, the push is accepted, no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
- TX path:
  - FSM states: IDLE -> START -> DATA -> STOP -> IDLE; each bit is held exactly DIV cycles.
  - uart_tx goes low on the cycle after the accepted write.
  - Data bits are sent LSB first; the stop bit is 1.
  - tx_busy=1 from the cycle after the accepted write until the final stop-bit cycle completes. A new write is accepted in the following cycle.
- rx_irq is registered and reflects state one cycle after any change.

Test Plan:
- Reset: hold ext_reset=0 for 5 cycles -> uart_tx=1, STATUS reads 0x0, CTRL reads 0, rx_irq=0.
- TX frame: write 0x55 to addr1 -> start bit, then bits 1,0,1,0,1,0,1,0, then stop bit, each exactly 234 clkout cycles. tx_busy=1 for 2340 cycles. A second write during the frame is ignored.
- RX single byte: drive 0xA3 at 115200 baud -> after the stop bit, STATUS[8:4]=1, RXDATA=0x1A3. A held ren pops once; the next read returns 0x000.
- RX overflow: send 17 bytes 0x00..0x10 without reading -> count=16, rx_overflow=1, reads return 0x00..0x0F. Writing 0x2 to addr2 clears the flag.
- Framing/false start: a 50-cycle low glitch -> no byte received. A frame with stop bit=0 -> frame_err=1 and count unchanged.
- IRQ and collision: CTRL=1 plus a received byte -> rx_irq=1; after the pop, rx_irq=0. A pop coincident with a push at full -> count stays 16 and no overflow.
